// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, FSM states and constants shared by the multiply/divide sequencer
package mdu_pkg;
  localparam logic [1:0] MDU_MULT  = 2'd0;
  localparam logic [1:0] MDU_MULTU = 2'd1;
  localparam logic [1:0] MDU_DIV   = 2'd2;
  localparam logic [1:0] MDU_DIVU  = 2'd3;
  typedef enum logic [1:0] {IDLE, CALC, FIX} mdu_state_e;
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;
endpackage

// File: rtl/mdu_core.sv
// mdu_core: one shift-add multiply or restoring-divide iteration over the 2*WIDTH accumulator
module mdu_core #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  input  logic               div,
  output logic [2*WIDTH-1:0] nxt
);
  logic [WIDTH:0] sum, sh;
  logic [WIDTH-1:0] rem;
  logic ge;
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    // remainder shifted left with the next dividend bit needs one extra bit before the trial subtract
    sh = acc[2*WIDTH-1:WIDTH-1];
    ge = sh >= {1'b0, opnd};
    rem = ge ? WIDTH'(sh - {1'b0, opnd}) : sh[WIDTH-1:0];
    nxt = div ? {rem, acc[WIDTH-2:0], ge} : {sum, acc[WIDTH-1:1]};
  end
endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with hazard stall
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             hilo_rd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);
  mdu_state_e state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH-1:0] acc, acc_n, acc_neg;
  logic [WIDTH-1:0] opnd, mag_a, mag_b, res_hi, res_lo;
  logic is_div, neg_q, neg_r, sgn, sa, sb, op_div, div0, wr_fix, done_p;
  mdu_core #(.WIDTH(WIDTH)) u_core (.acc(acc), .opnd(opnd), .div(is_div), .nxt(acc_n));
  always_comb begin
    sgn = op == MDU_MULT || op == MDU_DIV;
    op_div = op == MDU_DIV || op == MDU_DIVU;
    sa = sgn & a[WIDTH-1];
    sb = sgn & b[WIDTH-1];
    mag_a = sa ? -a : a;
    mag_b = sb ? -b : b;
    div0 = op_div && b == '0;
    acc_neg = -acc;
    res_hi = is_div ? (neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH])
                    : (neg_q ? acc_neg[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH]);
    res_lo = is_div ? (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0])
                    : (neg_q ? acc_neg[WIDTH-1:0] : acc[WIDTH-1:0]);
    wr_fix = state == FIX && !cancel;
    busy = state != IDLE;
    stall = busy & (start | hilo_rd | wr_hi | wr_lo);
    state_n = state == IDLE ? (start ? (div0 ? FIX : CALC) : IDLE)
            : state == CALC ? (cancel ? IDLE : (cnt == CNT_W'(WIDTH - 1) ? FIX : CALC))
            : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      done_p <= 1'b0;
      done <= 1'b0;
      acc <= '0;
      opnd <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      state <= state_n;
      done_p <= wr_fix;
      done <= done_p;
      if (state == IDLE && start) begin
        cnt <= '0;
        is_div <= op_div;
        opnd <= mag_b;
        neg_q <= !div0 && (sa ^ sb);
        neg_r <= !div0 && sa;
        // divide by zero: preload the final HI=a / LO=all-ones pattern and skip the loop
        acc <= div0 ? {a, WIDTH'(DIV0_LO)} : {{WIDTH{1'b0}}, mag_a};
      end else if (state == IDLE) begin
        if (wr_hi) hi <= wdata;
        if (wr_lo) lo <= wdata;
      end
      if (state == CALC) begin
        acc <= acc_n;
        cnt <= cnt + 1'b1;
      end
      if (wr_fix) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end
endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Iterative multiply/divide sequencer that owns the HI/LO resource for the 5-stage pipeline.
- Accepts MULT/MULTU/DIV/DIVU from EX and runs a 32-step shift-add or restoring-divide loop.
- Writes HI/LO on completion and accepts MTHI/MTLO writes.
- Raises a stall to the hazard logic whenever ID/EX touches HI/LO while an operation is in flight.

Parameters:
- WIDTH, 32, operand width; HI/LO width; iteration count.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  EX issues a mult/div this cycle
- op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- a  in  WIDTH  rs operand (forwarded)
- b  in  WIDTH  rt operand (forwarded)
- cancel  in  1  flush of the issuing instruction; abort the current operation
- wr_hi  in  1  MTHI write
- wr_lo  in  1  MTLO write
- wdata  in  WIDTH  MTHI/MTLO data
- hilo_rd  in  1  ID holds MFHI/MFLO
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse: HI/LO were just updated by an operation
- stall  out  1  pipeline must hold IF/ID/EX

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0.
  - Reset mid-operation aborts the operation with no HI/LO write.
- States:
  - IDLE: start=1 latches op, sign flags and operand magnitudes (abs for MULT/DIV; raw for MULTU/DIVU), sets counter=0, goes to CALC.
    - DIV/DIVU with b=0 goes to FIX directly.
  - CALC: one iteration per cycle; counter++; at counter==WIDTH-1 goes to FIX.
    - Multiply: 2*WIDTH product register; add multiplicand if LSB set, then shift right.
    - Divide: restoring; shift remainder:dividend left, trial subtract, set quotient bit if non-negative.
  - FIX: sign-correct the result, write HI/LO, pulse done at the next cycle, return to IDLE.
    - Multiply: negate the 64-bit product if sign(a)^sign(b) and op=MULT.
    - Divide: quotient negated if sign(a)^sign(b); remainder takes sign(a); LO=quotient, HI=remainder.
- Divide by zero: HI=a, LO=all ones, latency 2 cycles.
- Latency: start sampled at edge N; HI/LO valid and done=1 after edge N+34 (1 load + 32 CALC + 1 FIX). busy=1 from after edge N until the edge on which FIX writes.
- stall = busy & (start | hilo_rd | wr_hi | wr_lo). Combinational; also covers the FIX cycle.
- Requests while busy are not accepted; the stalled pipeline re-presents them.
- In IDLE, wr_hi/wr_lo write wdata at the edge.
- start together with wr_hi/wr_lo in IDLE: start wins; the write is dropped.
- cancel=1 while busy: return to IDLE at the next edge; HI/LO unchanged; no done. cancel in IDLE is ignored.
- cancel and the FIX write in the same cycle: cancel wins; no write.
- Sign handling: abs(-2^31) = 2^31 held in WIDTH bits as unsigned; products are correct modulo 2^64.
- DIV -2^31/-1: LO=0x80000000, HI=0.

Decomposition:
- Shared package mdu_pkg:
  - op encodings MDU_MULT/MULTU/DIV/DIVU.
  - state enum IDLE/CALC/FIX.
  - DIV0_LO constant (all ones).
- One sub-module, mdu_core: per-iteration step datapath. Takes the product/remainder register plus operand and mode; returns the next register value. Purely combinational.
- mdu_seq holds the FSM, counter, sign flags, HI/LO and stall logic.

Test Plan:
- MULT a=0xFFFFFFFD(-3), b=5 -> after 34 cycles HI=0xFFFFFFFF, LO=0xFFFFFFF1; done high exactly 1 cycle.
- DIVU a=100, b=7 -> LO=0x0000000E, HI=0x00000002. DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=0x1234, b=0 -> done 2 cycles after start; HI=0x00001234, LO=0xFFFFFFFF.
- MULTU 0xFFFFFFFF*0xFFFFFFFF, then hilo_rd held from cycle N+1 -> stall=1 through the FIX cycle, 0 once done; HI=0xFFFFFFFE, LO=0x00000001.
- Preload HI=0xAA via wr_hi; start MULT 6*7, cancel at cycle N+10 -> busy drops next cycle, no done, HI=0xAA unchanged. Repeat with rst at N+10 -> HI=LO=0.
- In IDLE, assert start (MULTU 2*3) and wr_lo (0x55) in the same cycle -> LO=6, HI=0; the write is dropped.
